// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings, state type and sizing helper for the HI/LO multiply/divide unit
package mdu_pkg;

    // Operation encodings on the op port; 11x is a no-op
    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_DIVU  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_t;

    // Width of a down-counter that must hold the value n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - iterative restoring radix-2 divider with sign fix-up
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] raw_a_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             zero_q;
    logic             fix_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // Operand magnitudes and the trial subtraction for the current quotient bit
    always_comb begin
        a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dsr_q};
    end

    // Load on start, then one quotient bit per cycle; fix_q marks the sign-correction cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            raw_a_q <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            fix_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (flush) begin
            cnt_q <= '0;
            fix_q <= 1'b0;
        end else if (start) begin
            quo_q   <= a_mag;
            rem_q   <= '0;
            dsr_q   <= b_mag;
            raw_a_q <= a;
            q_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_q <= is_signed & a[WIDTH-1];
            zero_q  <= (b == '0);
            fix_q   <= 1'b0;
            cnt_q   <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            // A clear borrow bit means the shifted remainder covers the divisor
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - CNT_W'(1);
            fix_q <= (cnt_q == CNT_W'(1));
        end else begin
            fix_q <= 1'b0;
        end
    end

    // Divide by zero returns all-ones and the raw dividend; otherwise restore the signs
    always_comb begin
        quotient  = zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        remainder = zero_q ? raw_a_q : (r_neg_q ? -rem_q : rem_q);
    end

    assign count = cnt_q;
    assign done  = fix_q;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - HI/LO register pair with pipelined multiply and iterative divide
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int MCNT_W = cnt_width(MUL_STAGES);

    mdu_state_t state;
    mdu_state_t next_state;

    logic [MCNT_W-1:0]  mul_cnt;
    logic [2*WIDTH-1:0] mul_pipe [MUL_STAGES];
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    logic accept;
    logic mul_go;
    logic div_go;
    logic mul_fin;
    logic div_fin;
    logic wr_hi;
    logic wr_lo;

    logic [CNT_W-1:0] div_count;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    mdu_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .flush     (flush),
        .is_signed (op[0]),
        .a         (a),
        .b         (b),
        .count     (div_count),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Full-width product; the low 2*WIDTH bits of a sign-extended product are the signed result
    always_comb begin
        ext_a   = op[0] ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b   = op[0] ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product = ext_a * ext_b;
    end

    // Next-state decode plus the one-cycle strobes that steer the HI/LO writes
    always_comb begin
        next_state = state;
        accept     = (state == IDLE) && start && !flush;
        mul_go     = 1'b0;
        div_go     = 1'b0;
        mul_fin    = 1'b0;
        div_fin    = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_MULTU, MDU_MULT: begin
                            next_state = MUL;
                            mul_go     = 1'b1;
                        end
                        MDU_DIVU, MDU_DIV: begin
                            next_state = DIV;
                            div_go     = 1'b1;
                        end
                        MDU_MTHI: wr_hi = 1'b1;
                        MDU_MTLO: wr_lo = 1'b1;
                        default:  ;
                    endcase
                end
            end
            MUL: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (mul_cnt == MCNT_W'(1)) begin
                    next_state = IDLE;
                    mul_fin    = 1'b1;
                end
            end
            DIV: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (div_count == CNT_W'(1)) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
                div_fin    = !flush && div_done;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Multiply latency counter; clearing it on flush discards whatever is in the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_cnt <= '0;
        end else if (flush) begin
            mul_cnt <= '0;
        end else if (mul_go) begin
            mul_cnt <= MCNT_W'(MUL_STAGES);
        end else if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MCNT_W'(1);
        end
    end

    // Product pipeline: stage 0 captures at accept, later stages just follow
    always_ff @(posedge clk) begin
        if (mul_go) begin
            mul_pipe[0] <= product;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    // HI/LO registers and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= mul_fin | div_fin;
            if (mul_fin) begin
                {hi, lo} <= mul_pipe[MUL_STAGES-1];
            end
            if (div_fin) begin
                hi <= remainder;
                lo <= quotient;
            end
            if (wr_hi) begin
                hi <= a;
            end
            if (wr_lo) begin
                lo <= a;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard bench for mdu_hilo at WIDTH=32/MUL_STAGES=2 and WIDTH=16/MUL_STAGES=1
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int MS   = 2;
    localparam int MS16 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start16 = 1'b0;
    logic [2:0]  op16 = 3'b111;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        flush16 = 1'b0;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp16_q[$];

    mdu_hilo #(.WIDTH(32), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_hilo #(.WIDTH(16), .MUL_STAGES(MS16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .flush(flush16),
        .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    always #5 clk = ~clk;

    // Reference model for 32-bit operations, returns {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint ux, uy, sx, sy, p, q, r;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MDU_MULTU: begin p = ux * uy; return p; end
            MDU_MULT:  begin p = sx * sy; return p; end
            MDU_DIVU: begin
                if (uy == 0) return {x, 32'hFFFF_FFFF};
                q = ux / uy; r = ux % uy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (uy == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy; r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Drive one start pulse; with now=1 the pulse begins immediately (caller is at a negedge)
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit now = 0);
        if (!now) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'b111;
    endtask

    // Wait for done, bounded; lat counts clock edges after the accept edge
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi actual=%h required=0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo actual=%h required=0", lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b required=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [63:0] e;
        int lat, bn;
        exp_q.push_back(64'h0000_0001_FFFF_FFFE);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        n_checks++; if (lat !== MS) begin n_fail++; $display("FAIL multu_latency actual=%0d required=%0d", lat, MS); end
        n_checks++; if (bn !== MS) begin n_fail++; $display("FAIL multu_busy_cycles actual=%0d required=%0d", bn, MS); end
        n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL multu_result actual=%h required=%h", {hi, lo}, e); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse actual=%b required=0", done); end

        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'h7);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL mult_result actual=%h required=%h", {hi, lo}, e); end
    endtask

    task automatic test_mthi_mtlo;
        issue(MDU_MTLO, 32'h1234, 32'h0);
        n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo actual=%h required=00001234", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtlo_hi actual=%h required=ffffffff", hi); end
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_no_done actual=%b%b required=00", done, busy); end
        issue(MDU_MTHI, 32'hABCD_0001, 32'h0);
        n_checks++; if (hi !== 32'hABCD_0001) begin n_fail++; $display("FAIL mthi_hi actual=%h required=abcd0001", hi); end
    endtask

    task automatic test_div;
        logic [63:0] e;
        int lat, bn;
        logic [2:0]  ops [4] = '{MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd100, 32'h55, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] es  [4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                                 64'h0000_0055_FFFF_FFFF, 64'h0000_0000_8000_0000};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(es[i]);
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bn);
            e = exp_q.pop_front();
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div%0d_latency actual=%0d required=33", i, lat); end
            n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL div%0d_result actual=%h required=%h", i, {hi, lo}, e); end
        end
        n_checks++; if (bn !== 33) begin n_fail++; $display("FAIL div_busy_cycles actual=%0d required=33", bn); end
    endtask

    task automatic test_flush;
        bit saw;
        issue(MDU_MTHI, 32'hCAFE_0001, 32'h0);
        issue(MDU_MTLO, 32'hBEEF_0002, 32'h0);
        issue(MDU_DIV, 32'd100, 32'd3);
        repeat (4) @(negedge clk);
        op = MDU_MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored actual=%b required=1", busy); end
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy actual=%b required=0", busy); end
        saw = 0;
        repeat (40) begin @(negedge clk); if (done) saw = 1; end
        n_checks++; if (saw) begin n_fail++; $display("FAIL flush_no_done actual=1 required=0"); end
        n_checks++; if ({hi, lo} !== 64'hCAFE_0001_BEEF_0002) begin n_fail++; $display("FAIL flush_hilo actual=%h required=cafe0001beef0002", {hi, lo}); end

        op = MDU_MTLO; a = 32'h777; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_checks++; if (lo !== 32'hBEEF_0002) begin n_fail++; $display("FAIL idle_flush_blocks_mtlo actual=%h required=beef0002", lo); end

        issue(MDU_MULTU, 32'd3, 32'd4);
        repeat (MS - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_at_completion actual=%b%b required=00", done, busy); end
        n_checks++; if ({hi, lo} !== 64'hCAFE_0001_BEEF_0002) begin n_fail++; $display("FAIL flush_at_completion_hilo actual=%h required=cafe0001beef0002", {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        int lat, bn;
        exp_q.push_back(64'h0000_0000_0000_0015);
        issue(MDU_MULTU, 32'd3, 32'd7);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_first actual=%h required=%h", {hi, lo}, e); end
        exp_q.push_back(64'h0000_0001_0000_0006);
        issue(MDU_DIVU, 32'd19, 32'd3, 1);
        wait_done(lat, bn);
        e = exp_q.pop_front();
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency actual=%0d required=33", lat); end
        n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_second actual=%h required=%h", {hi, lo}, e); end
    endtask

    task automatic test_random;
        logic [63:0] e;
        logic [2:0]  o;
        logic [31:0] x, y;
        int lat, bn;
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            exp_q.push_back(model(o, x, y));
            issue(o, x, y);
            wait_done(lat, bn);
            e = exp_q.pop_front();
            n_checks++; if (lat !== (o[1] ? 33 : MS)) begin n_fail++; $display("FAIL rand%0d_latency op=%0d actual=%0d", i, o, lat); end
            n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL rand%0d_result op=%0d a=%h b=%h actual=%h required=%h", i, o, x, y, {hi, lo}, e); end
        end
    endtask

    task automatic test_reset_mid_div;
        bit saw;
        issue(MDU_MTHI, 32'h11, 32'h0);
        issue(MDU_DIV, 32'd50, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL async_reset_hilo actual=%h required=0", {hi, lo}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy actual=%b required=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (40) begin @(negedge clk); if (done) saw = 1; end
        n_checks++; if (saw || hi !== 32'd0) begin n_fail++; $display("FAIL reset_discards_div actual=%b/%h required=0/0", saw, hi); end
    endtask

    task automatic test_width16;
        logic [31:0] e;
        int lat;
        logic [2:0]  ops [3] = '{MDU_MULTU, MDU_MULT, MDU_DIV};
        logic [15:0] as  [3] = '{16'hFFFF, 16'hFFFD, 16'hFFF9};
        logic [15:0] bs  [3] = '{16'h0002, 16'h0007, 16'h0002};
        logic [31:0] es  [3] = '{32'h0001_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD};
        int          ls  [3] = '{MS16, MS16, 17};
        for (int i = 0; i < 3; i++) begin
            exp16_q.push_back(es[i]);
            @(negedge clk);
            op16 = ops[i]; a16 = as[i]; b16 = bs[i]; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            lat = 0;
            while (!done16 && lat < 100) begin @(negedge clk); lat++; end
            e = exp16_q.pop_front();
            n_checks++; if (lat !== ls[i]) begin n_fail++; $display("FAIL w16_%0d_latency actual=%0d required=%0d", i, lat, ls[i]); end
            n_checks++; if ({hi16, lo16} !== e) begin n_fail++; $display("FAIL w16_%0d_result actual=%h required=%h", i, {hi16, lo16}, e); end
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mthi_mtlo;
        test_div;
        test_flush;
        test_back_to_back;
        test_random;
        test_width16;
        test_reset_mid_div;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core.
- Sits beside the execute-stage ALU and generalises the single-cycle HI/LO write path to WIDTH-bit signed/unsigned multiply and divide.
- Multiply is pipelined and divide is iterative; the unit asserts busy so the hazard unit can stall later HI/LO consumers.
- Supports flush of an in-flight operation on branch/exception squash.

Parameters:
- WIDTH, 32, operand width and HI/LO register width (>=4, even).
- MUL_STAGES, 2, multiply latency in cycles (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  operation request from execute stage.
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- a  input  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data).
- b  input  WIDTH  rt operand (divisor, multiplier).
- flush  input  1  abort the in-flight multiply/divide.
- busy  output  1  multiply/divide in progress; start is ignored while high.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a multiply/divide result.
- hi  output  WIDTH  HI register, registered.
- lo  output  WIDTH  LO register, registered.

Behaviour:
- Reset: clk and rst as above, with rst asynchronous and active-high.
  - On reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
  - Reset mid-operation discards the operation with no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- Accept: start is sampled at an edge only when state=IDLE and flush=0. Otherwise start is ignored, and the hazard unit must hold the instruction.
- MTHI/MTLO:
  - At the accept edge, hi<=a or lo<=a.
  - State stays IDLE; busy and done stay 0.
  - The new value is visible the next cycle.
- MULT/MULTU:
  - The 2*WIDTH product passes through MUL_STAGES registers; the signed form uses sign-extended operands.
  - Accept edge E0: state=MUL, busy=1.
  - At edge E0+MUL_STAGES: {hi,lo}<=product, done=1 for one cycle, busy=0, state=IDLE.
- DIV/DIVU:
  - Restoring radix-2 division on magnitudes. The signed form takes abs values and records the quotient sign (a^b sign bits) and remainder sign (a sign bit).
  - Accept edge E0: state=DIV, counter=WIDTH, busy=1.
  - Each DIV cycle shifts one quotient bit and decrements the counter.
  - When counter reaches 0, go to FIX. FIX applies sign correction.
  - At edge E0+WIDTH+1: lo<=quotient, hi<=remainder, done=1, busy=0, state=IDLE.
- Divide by zero (b==0), signed or unsigned:
  - Full latency is kept.
  - Result: lo=all ones, hi=a (the raw dividend).
- Signed overflow (a=most negative, b=-1): lo=most negative, hi=0, with no trap.
- Flush:
  - In MUL/DIV/FIX, at the next edge: state=IDLE, busy=0, done=0, hi/lo unchanged, in-flight pipeline contents discarded.
  - In IDLE, flush only blocks a same-cycle start, including MTHI/MTLO.
- Flush at the completion edge: flush wins and there is no HI/LO write.
- Back-to-back operations: a start in the cycle after done is accepted normally.
- done never asserts for MTHI/MTLO or no-op.
- Counter width is clog2(WIDTH+1). All arithmetic is unsigned on magnitudes, and the product register is 2*WIDTH bits.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings (MDU_MULTU..MDU_MTLO);
  - the state enum (IDLE, MUL, DIV, FIX);
  - localparam helpers CNT_W = clog2(WIDTH+1).
- One sub-module, mdu_divider: iterative restoring divider with start/flush in and done/quotient/remainder out.
- The multiplier pipeline and the HI/LO registers stay in mdu_hilo.

Test Plan:
- MULTU a=0xFFFFFFFF b=0x2 -> after 2 cycles hi=0x00000001, lo=0xFFFFFFFE, done pulses once, busy high exactly 2 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MTLO a=0x1234 -> lo=0x1234 next cycle, hi unchanged, no done.
- DIV a=-7 (0xFFFFFFF9) b=2 -> after 33 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x55 b=0 -> lo=0xFFFFFFFF, hi=0x55; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIV, assert flush at cycle 10 -> busy=0 the next cycle, hi/lo keep prior values, no done; start during busy is ignored.
- Assert rst mid-DIV -> hi=lo=0 and busy=0 immediately (asynchronous); repeat the multiply checks with WIDTH=16, MUL_STAGES=1.
